// File: rtl/led_meter_ctrl.sv
// Stereo peak meter: per-channel window peak, 0..4 bar quantization, peak hold with
// one-step decay, and an 8-LED bar pattern refreshed once every TICK_CNT clocks.
module led_meter_ctrl #(
  parameter int TICK_CNT   = 2500000,
  parameter int HOLD_TICKS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        smpl_vld,
  input  logic [15:0] lft_smpl,
  input  logic [15:0] rht_smpl,
  output logic [7:0]  LED,
  output logic        tick,
  output logic [1:0]  dbg_state_o
);

  localparam int CW = (TICK_CNT > 2) ? $clog2(TICK_CNT) : 2;
  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Channel index 1 = left, 0 = right.
  logic [1:0][14:0]   pk_q, pk_d;
  logic [1:0][14:0]   snap_q, snap_d;
  logic [1:0][2:0]    lvl_q, lvl_d;
  logic [1:0][HW-1:0] hold_q, hold_d;
  logic [7:0]         led_q, led_d;
  logic               tick_q, tick_d;

  logic               term;
  logic               accum;
  logic [1:0][14:0]   smpl_mag;
  logic [1:0][14:0]   pk_cand;
  logic [1:0][2:0]    new_lvl;

  function automatic logic [14:0] mag15(input logic [15:0] s);
    logic [14:0] r;
    if (!s[15])             r = s[14:0];
    else if (s == 16'h8000) r = 15'h7fff;
    else                    r = ~s[14:0] + 15'd1;
    return r;
  endfunction

  function automatic logic [2:0] quant(input logic [14:0] m);
    logic [2:0] r;
    if (m < 15'd256)        r = 3'd0;
    else if (m < 15'd1024)  r = 3'd1;
    else if (m < 15'd4096)  r = 3'd2;
    else if (m < 15'd16384) r = 3'd3;
    else                    r = 3'd4;
    return r;
  endfunction

  function automatic logic [3:0] bar_up(input logic [2:0] d);
    logic [3:0] r;
    case (d)
      3'd0:    r = 4'b0000;
      3'd1:    r = 4'b0001;
      3'd2:    r = 4'b0011;
      3'd3:    r = 4'b0111;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] bar_down(input logic [2:0] d);
    logic [3:0] r;
    case (d)
      3'd0:    r = 4'b0000;
      3'd1:    r = 4'b1000;
      3'd2:    r = 4'b1100;
      3'd3:    r = 4'b1110;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  assign term  = (state_q == S_RUN) && (cnt_q == CW'(TICK_CNT - 1));
  assign accum = (state_q == S_RUN) || (state_q == S_UPDATE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (en) state_d = S_RUN;
      end
      S_RUN: begin
        if (term) begin
          state_d = S_UPDATE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_UPDATE: begin
        state_d = S_RUN;
        cnt_d   = cnt_q + 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (!en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // A sample in the terminal cycle folds into the closing snapshot; one in UPDATE
  // lands in the freshly cleared peak and so opens the next window.
  always_comb begin
    smpl_mag[1] = mag15(lft_smpl);
    smpl_mag[0] = mag15(rht_smpl);
    pk_d   = pk_q;
    snap_d = snap_q;
    lvl_d  = lvl_q;
    hold_d = hold_q;
    for (int ch = 0; ch < 2; ch++) begin
      pk_cand[ch] = (smpl_vld && (smpl_mag[ch] > pk_q[ch])) ? smpl_mag[ch] : pk_q[ch];
      new_lvl[ch] = quant(snap_q[ch]);
      if (accum) pk_d[ch] = term ? 15'd0 : pk_cand[ch];
      if (term)  snap_d[ch] = pk_cand[ch];
      if (state_q == S_UPDATE) begin
        if (new_lvl[ch] >= lvl_q[ch]) begin
          lvl_d[ch]  = new_lvl[ch];
          hold_d[ch] = HW'(HOLD_TICKS);
        end else if (hold_q[ch] != '0) begin
          hold_d[ch] = hold_q[ch] - 1'b1;
        end else begin
          lvl_d[ch] = lvl_q[ch] - 3'd1;
        end
      end
    end
    led_d  = (state_q == S_UPDATE) ? {bar_up(lvl_d[1]), bar_down(lvl_d[0])} : led_q;
    tick_d = (state_q == S_UPDATE);
  end

  // Dropping enable behaves like reset, so an in-flight UPDATE never reaches the display.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      state_q <= (rst_n) ? state_d : S_IDLE;
      cnt_q   <= '0;
      pk_q    <= '0;
      snap_q  <= '0;
      lvl_q   <= '0;
      hold_q  <= '0;
      led_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pk_q    <= pk_d;
      snap_q  <= snap_d;
      lvl_q   <= lvl_d;
      hold_q  <= hold_d;
      led_q   <= led_d;
      tick_q  <= tick_d;
    end
  end

  assign LED         = led_q;
  assign tick        = tick_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_led_meter_ctrl.sv
// Directed bench for led_meter_ctrl: expected (cycle, LED) pairs are queued by the
// driver and matched by a monitor whenever the DUT raises tick.
module tb_led_meter_ctrl;

  localparam int TICK = 16;
  localparam int HOLD = 2;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        smpl_vld;
  logic [15:0] lft_smpl;
  logic [15:0] rht_smpl;
  logic [7:0]  LED;
  logic        tick;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];

  led_meter_ctrl #(.TICK_CNT(TICK), .HOLD_TICKS(HOLD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .smpl_vld    (smpl_vld),
    .lft_smpl    (lft_smpl),
    .rht_smpl    (rht_smpl),
    .LED         (LED),
    .tick        (tick),
    .dbg_state_o (dbg_state)
  );

  // Clock and edge counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_n <= edge_n + 1;

  // Monitor: every tick must match the oldest queued expectation in time and value.
  always @(negedge clk) begin
    if (tick === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_tick: got tick at edge %0d, want no tick", edge_n);
      end else begin
        logic [7:0] e_led;
        int         e_cyc;
        e_led = exp_q.pop_front();
        e_cyc = exp_cyc_q.pop_front();
        if (edge_n != e_cyc) begin
          bad++;
          $display("FAIL tick_time: got edge %0d, want edge %0d", edge_n, e_cyc);
        end
        total++;
        if (LED !== e_led) begin
          bad++;
          $display("FAIL tick_led: got %b, want %b (edge %0d)", LED, e_led, edge_n);
        end
      end
    end
  end

  // Driver tasks
  task automatic expect_tick(input int cyc, input logic [7:0] led);
    exp_cyc_q.push_back(cyc);
    exp_q.push_back(led);
  endtask

  task automatic wait_edge(input int target);
    while (edge_n < target) @(negedge clk);
  endtask

  task automatic pulse(input logic [15:0] l, input logic [15:0] r);
    smpl_vld = 1'b1;
    lft_smpl = l;
    rht_smpl = r;
    @(negedge clk);
    smpl_vld = 1'b0;
    lft_smpl = '0;
    rht_smpl = '0;
  endtask

  task automatic check_now(input string name, input logic [7:0] led);
    total++;
    if (LED !== led) begin
      bad++;
      $display("FAIL %s_led: got %b, want %b", name, LED, led);
    end
    total++;
    if (tick !== 1'b0) begin
      bad++;
      $display("FAIL %s_tick: got %b, want 0", name, tick);
    end
  endtask

  task automatic drop_en(input string name);
    en = 1'b0;
    @(negedge clk);
    check_now(name, 8'h00);
    repeat (4) @(negedge clk);
  endtask

  // Stimulus
  initial begin
    int base;
    int r;
    logic [7:0] decay_seq[7];
    decay_seq = '{8'hF0, 8'hF0, 8'hF0, 8'h70, 8'h30, 8'h10, 8'h00};
    rst_n    = 1'b0;
    en       = 1'b0;
    smpl_vld = 1'b0;
    lft_smpl = '0;
    rht_smpl = '0;
    repeat (3) @(negedge clk);
    check_now("reset", 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Level mapping, then hold keeping both levels, then decay once holds expire
    en = 1'b1;
    base = edge_n;
    expect_tick(base + 18, 8'b0001_1110);
    expect_tick(base + 34, 8'b0001_1110);
    expect_tick(base + 50, 8'b0001_1110);
    expect_tick(base + 66, 8'b0001_1100);
    wait_edge(base + 5);
    pulse(16'(300), 16'(-5000));
    wait_edge(base + 25);
    pulse(16'(1023), 16'(255));
    wait_edge(base + 70);
    drop_en("off_a");

    // Saturation, then a mid-window drop whose sample must not survive
    en = 1'b1;
    base = edge_n;
    expect_tick(base + 18, 8'hFF);
    wait_edge(base + 3);
    pulse(16'(-32768), 16'(16384));
    wait_edge(base + 22);
    pulse(16'(20000), 16'(0));
    wait_edge(base + 26);
    drop_en("mid_window");

    // Fresh enable: threshold just below level 4, left shows nothing from before
    en = 1'b1;
    base = edge_n;
    expect_tick(base + 18, 8'b0000_1110);
    wait_edge(base + 2);
    pulse(16'(0), 16'(16383));
    wait_edge(base + 22);
    drop_en("off_b");

    // Hold for two ticks, then one-step decay to zero
    en = 1'b1;
    base = edge_n;
    for (int k = 0; k < 7; k++) expect_tick(base + 18 + 16 * k, decay_seq[k]);
    wait_edge(base + 4);
    pulse(16'(20000), 16'(0));
    wait_edge(base + 16 * 7 + 6);
    drop_en("off_c");

    // Sample in the terminal cycle belongs to the closing window
    en = 1'b1;
    base = edge_n;
    expect_tick(base + 18, 8'b0000_1100);
    wait_edge(base + 16);
    pulse(16'(0), 16'(2000));
    wait_edge(base + 22);
    drop_en("off_d");

    // Sample in the UPDATE cycle belongs to the next window; then reset mid-window
    en = 1'b1;
    base = edge_n;
    expect_tick(base + 18, 8'h00);
    expect_tick(base + 34, 8'b0000_1100);
    wait_edge(base + 17);
    pulse(16'(0), 16'(2000));
    wait_edge(base + 40);
    rst_n = 1'b0;
    @(negedge clk);
    check_now("rst_mid", 8'h00);
    rst_n = 1'b1;
    r = edge_n;
    expect_tick(r + 18, 8'h00);
    wait_edge(r + 22);
    drop_en("off_e");

    // Enable dropped during UPDATE abandons the update
    en = 1'b1;
    base = edge_n;
    wait_edge(base + 5);
    pulse(16'(20000), 16'(20000));
    wait_edge(base + 17);
    en = 1'b0;
    @(negedge clk);
    check_now("upd_abandon", 8'h00);
    repeat (20) @(negedge clk);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_ticks: got %0d unmatched, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout at edge %0d, want completion", edge_n);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_meter_ctrl.md
Name: led_meter_ctrl

Overview:
- Stereo peak-meter scheduler driving the 8-LED bar display from the audio output datapath.
- Watches the left/right output sample stream and tracks per-channel peak magnitude over a fixed update window.
- Once per window, quantizes each peak to a 0..4 bar level, applies peak-hold and one-step decay, and registers the LED pattern.
- Owns the display update timing that a free-running divided clock would otherwise provide; fully synchronous to clk.

Parameters:
- TICK_CNT, 2500000: update period in clk cycles (minimum 4).
- HOLD_TICKS, 8: number of update ticks a new peak level is held before decay starts.

Ports:
- clk  in  1  system clock; only clock in the block.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- en  in  1  meter enable; low blanks the display and clears all state.
- smpl_vld  in  1  one-cycle strobe; lft_smpl/rht_smpl valid this cycle.
- lft_smpl  in  16  left output sample, signed two's complement.
- rht_smpl  in  16  right output sample, signed two's complement.
- LED  out  8  bar display; [7:4] left, [3:0] right.
- tick  out  1  registered one-cycle pulse marking each LED update.

Behaviour:
- Reset (rst_n low at posedge clk):
  - State IDLE; period counter, window peaks, snapshots, displayed levels and hold counters all 0.
  - LED=8'h00, tick=0.
- FSM states:
  - IDLE: counter held at 0.
  - RUN: accumulate samples, counter increments.
  - UPDATE: one cycle; compute levels and load the display.
- FSM transitions:
  - IDLE->RUN when en=1. RUN is entered with cnt=0.
  - RUN->UPDATE when cnt==TICK_CNT-1; cnt wraps to 0 in that same cycle.
  - UPDATE->RUN unconditionally; cnt keeps incrementing through UPDATE. The update period is therefore exactly TICK_CNT cycles.
  - en=0 in any state -> IDLE next cycle. Clears window peaks, snapshots, display levels, hold counters and LED. tick=0.
- Magnitude: mag = |sample|, 15-bit unsigned. -32768 saturates to 32767.
- Window accumulation:
  - Each smpl_vld cycle in RUN or UPDATE updates the per-channel window peak: pk <= max(pk, mag).
- Window close (terminal RUN cycle T):
  - snap <= max(pk, mag of any sample valid at T). A sample at T belongs to the closing window.
  - pk <= 0.
  - A sample valid in the UPDATE cycle (T+1) starts the new window (pk <= its mag).
- Quantization of snap:
  - <256 -> 0
  - <1024 -> 1
  - <4096 -> 2
  - <16384 -> 3
  - otherwise -> 4
- Hold/decay, per channel, evaluated in UPDATE with new level L and displayed level D:
  - If L>=D: D<=L, hold<=HOLD_TICKS.
  - Else if hold!=0: hold<=hold-1, D unchanged.
  - Else: D<=D-1.
- Bar encoding:
  - Left, LED[7:4] grows upward from bit 4: D=0..4 -> 0000, 0001, 0011, 0111, 1111.
  - Right, LED[3:0] grows downward from bit 3: D=0..4 -> 0000, 1000, 1100, 1110, 1111.
- Latency: terminal cycle T; UPDATE at T+1; new LED value and tick=1 visible at T+2. tick is high for exactly that one cycle.
- Reset or en drop during UPDATE: the update is abandoned. No tick; LED reads 0 next cycle.
- First tick after enabling: en sampled high at cycle 0 in IDLE -> tick at cycle TICK_CNT+2.
- No samples in a window: L=0 for both channels, so decay proceeds.

Test Plan:
- Reset: TICK_CNT=16, run with LED nonzero, pull rst_n low one cycle mid-window -> next edge LED=8'h00, tick=0; with en held high, first tick is 18 cycles after rst_n returns high.
- Level mapping: one window with lft=+300, rht=-5000 -> at tick LED=8'b0001_1110. Next window lft=+1023, rht=+255 -> LED=8'b0001_1110, since hold keeps both levels.
- Saturation/threshold: lft=-32768, rht=+16384 -> LED=8'hFF. rht=+16383 alone in a fresh enable -> LED[3:0]=1110.
- Hold/decay: HOLD_TICKS=2, one window with lft=+20000, then silence -> LED[7:4] over successive ticks = 1111, 1111, 1111, 0111, 0011, 0001, 0000.
- Window boundary: rht=+2000 in terminal cycle T -> next tick shows LED[3:0]=1100. rht=+2000 only in UPDATE cycle -> that tick shows 0000 and the following tick shows 1100.
- Enable: drop en mid-window -> LED=0 next cycle, no tick while low. Re-assert en -> first tick exactly TICK_CNT+2 cycles later, LED reflecting only post-enable samples.
